fifo_stream_mux: RTL

Parametrised N-channel merger for fifo_stream conduits (fifo_data / fifo_write / fifo_send), as produced by the DMA FIFO subsystems. Each channel writes into a private buffer. A round-robin arbiter forwards whole segments (words up to and including a send) onto one output fifo_stream toward the host-side FIFO. Downstream backpressure and per-channel overflow reporting are added.

---
 rtl/fifo_stream_mux_if.sv | 29 ++
 rtl/fifo_stream_mux.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_mux_if.sv
// Channel-side and host-side fifo_stream conduits of fifo_stream_mux.
// The slave modport is the mux's own view; master is the driver/consumer view.
interface fifo_stream_mux_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 256
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] in_fifo_data;
  logic [NUM_CH-1:0]        in_fifo_write;
  logic [NUM_CH-1:0]        in_fifo_send;
  logic [DATA_W-1:0]        out_fifo_data;
  logic                     out_fifo_write;
  logic                     out_fifo_send;
  logic [CH_W-1:0]          out_channel;
  logic                     out_ready;
  logic [NUM_CH-1:0]        ovf;
  logic                     ovf_clear;

  modport master (
    output in_fifo_data, in_fifo_write, in_fifo_send, out_ready, ovf_clear,
    input  out_fifo_data, out_fifo_write, out_fifo_send, out_channel, ovf
  );

  modport slave (
    input  in_fifo_data, in_fifo_write, in_fifo_send, out_ready, ovf_clear,
    output out_fifo_data, out_fifo_write, out_fifo_send, out_channel, ovf
  );
endinterface

// File: rtl/fifo_stream_mux.sv
// N-channel fifo_stream merger: per-channel buffers, segment-granular round-robin arbiter.
// Define FIFO_STREAM_MUX_PRIO_EN to give channel 0 strict priority over the others.
module fifo_stream_mux #(
  parameter int NUM_CH    = 5,
  parameter int DATA_W    = 256,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 0
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  fifo_stream_mux_if.slave   bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int ENT_W = DATA_W + 2;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t             r_state, w_state_next;
  logic [CH_W-1:0]    r_grant, w_grant_next;
  logic [CH_W-1:0]    r_last_grant, w_last_grant_next;
  logic [BST_W-1:0]   r_burst, w_burst_next;

  // Entry layout: {last, has_word, data}
  logic [ENT_W-1:0]   r_mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]   r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]   r_count [NUM_CH];
  logic [ENT_W-1:0]   w_entry_in [NUM_CH];

  logic [NUM_CH-1:0]  w_enq_req, w_enq, w_full, w_nonempty, w_pop;
  logic [NUM_CH-1:0]  r_ovf;
  logic               w_pop_any;
  logic [ENT_W-1:0]   w_head;
  logic               w_head_word, w_head_last, w_burst_hit;
  logic               w_found;
  logic [CH_W-1:0]    w_pick;
  int                 w_idx;

  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_write, r_out_send;
  logic [CH_W-1:0]    r_out_channel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      assign w_entry_in[gi] = {bus.in_fifo_send[gi], bus.in_fifo_write[gi],
                               bus.in_fifo_data[gi*DATA_W +: DATA_W]};
      assign w_enq_req[gi]  = bus.in_fifo_write[gi] | bus.in_fifo_send[gi];
      assign w_full[gi]     = (r_count[gi] == CNT_W'(DEPTH));
      assign w_enq[gi]      = w_enq_req[gi] & ~w_full[gi];
      assign w_nonempty[gi] = (r_count[gi] != '0);
      assign w_pop[gi]      = (r_state == ST_GRANT) && (r_grant == CH_W'(gi)) &&
                              bus.out_ready && w_nonempty[gi];

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          r_wr_ptr[gi] <= '0;
          r_rd_ptr[gi] <= '0;
          r_count[gi]  <= '0;
        end else begin
          if (w_enq[gi]) r_wr_ptr[gi] <= r_wr_ptr[gi] + PTR_W'(1);
          if (w_pop[gi]) r_rd_ptr[gi] <= r_rd_ptr[gi] + PTR_W'(1);
          case ({w_enq[gi], w_pop[gi]})
            2'b10:   r_count[gi] <= r_count[gi] + CNT_W'(1);
            2'b01:   r_count[gi] <= r_count[gi] - CNT_W'(1);
            default: r_count[gi] <= r_count[gi];
          endcase
        end
      end
    end
  endgenerate

  // Buffer storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_enq[c]) r_mem[c][r_wr_ptr[c]] <= w_entry_in[c];
    end
  end

  assign w_pop_any   = |w_pop;
  assign w_head      = r_mem[r_grant][r_rd_ptr[r_grant]];
  assign w_head_word = w_head[DATA_W];
  assign w_head_last = w_head[DATA_W+1];
  assign w_burst_hit = (MAX_BURST != 0) && w_head_word &&
                       ((r_burst + BST_W'(1)) == BST_W'(MAX_BURST));

  // A blocked enqueue always sets its flag, even against a simultaneous clear.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_ovf <= '0;
    else             r_ovf <= (r_ovf & ~{NUM_CH{bus.ovf_clear}}) | (w_enq_req & w_full);
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
`ifdef FIFO_STREAM_MUX_PRIO_EN
    if (w_nonempty[0]) begin
      w_found = 1'b1;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_CH;
      if (!w_found && (w_idx != 0) && w_nonempty[w_idx]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(w_idx);
      end
    end
`else
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_CH;
      if (!w_found && w_nonempty[w_idx]) begin
        w_found = 1'b1;
        w_pick  = CH_W'(w_idx);
      end
    end
`endif
  end

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_burst_next      = r_burst;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next = ST_GRANT;
          w_grant_next = w_pick;
          w_burst_next = '0;
`ifdef FIFO_STREAM_MUX_PRIO_EN
          // Channel 0 grants do not disturb the rotation among the others.
          if (w_pick != '0) w_last_grant_next = w_pick;
`else
          w_last_grant_next = w_pick;
`endif
        end
      end
      ST_GRANT: begin
        if (w_pop_any) begin
          if (w_head_word) w_burst_next = r_burst + BST_W'(1);
          if (w_head_last || w_burst_hit) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_burst      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_burst      <= w_burst_next;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_out_data    <= '0;
      r_out_write   <= 1'b0;
      r_out_send    <= 1'b0;
      r_out_channel <= '0;
    end else if (w_pop_any) begin
      r_out_data    <= w_head[DATA_W-1:0];
      r_out_write   <= w_head_word;
      r_out_send    <= w_head_last;
      r_out_channel <= r_grant;
    end else begin
      r_out_write   <= 1'b0;
      r_out_send    <= 1'b0;
    end
  end

  assign bus.out_fifo_data  = r_out_data;
  assign bus.out_fifo_write = r_out_write;
  assign bus.out_fifo_send  = r_out_send;
  assign bus.out_channel    = r_out_channel;
  assign bus.ovf            = r_ovf;
endmodule
